// File: rtl/fb_pixel_writer_if.sv
// Pixel-stream and framebuffer-RAM signals of the pixel writer.
// The slave modport is the writer's view; the master modport is the
// producer/RAM-controller side.
interface fb_pixel_writer_if #(
    parameter int unsigned AW = 19
);
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    pix_data;
    logic          pix_sof;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic          ram_ack;
    logic          frame_done;

    modport master (
        output pix_valid, pix_data, pix_sof, ram_ack,
        input  pix_ready, ram_addr, ram_wdata, ram_we, frame_done
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, ram_ack,
        output pix_ready, ram_addr, ram_wdata, ram_we, frame_done
    );
endinterface

// File: rtl/fb_pixel_writer.sv
// Framebuffer write engine: packs four RGB332 pixels per 32-bit word
// (lane 0 in the top byte), buffers packed words in a small FIFO and
// writes them to the framebuffer RAM over a request/acknowledge handshake.
module fb_pixel_writer #(
    parameter int unsigned AW         = 19,
    parameter int unsigned HSIZE      = 800,
    parameter int unsigned VSIZE      = 600,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    fb_pixel_writer_if.slave bus
);

    localparam int unsigned   FRAME_WORDS = HSIZE * VSIZE / 4;
    localparam int unsigned   PW          = $clog2(FIFO_DEPTH);
    localparam int unsigned   EW          = 1 + AW + 32;
    localparam logic [AW-1:0] LAST_IDX    = AW'(FRAME_WORDS - 1);
    localparam logic [AW-1:0] BASE        = AW'(BASE_ADDR);
    localparam logic [PW:0]   FULL_COUNT  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic {StIdle, StWrite} state_e;

    // Packer state; lanes 0..2 are held until the lane-3 pixel completes the word.
    logic [1:0]    r_lane;
    logic [AW-1:0] r_idx;
    logic [23:0]   r_pack;

    // FIFO entry: {last word of frame, address, data}.
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    state_e        r_state;
    state_e        w_state_d;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [31:0]   r_ram_wdata;
    logic          r_last;
    logic          r_frame_done;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_load;
    logic [1:0]    w_lane;
    logic [AW-1:0] w_idx;
    logic [EW-1:0] w_entry;

    assign bus.pix_ready  = (r_count != FULL_COUNT);
    assign bus.ram_we     = r_ram_we;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_wdata  = r_ram_wdata;
    assign bus.frame_done = r_frame_done;

    // SOF restarts packing at lane 0 of word 0, dropping any partial word.
    always_comb begin
        w_accept = bus.pix_valid && bus.pix_ready;
        w_lane   = bus.pix_sof ? 2'd0 : r_lane;
        w_idx    = bus.pix_sof ? '0 : r_idx;
        w_push   = w_accept && (w_lane == 2'd3);
        w_entry  = {(w_idx == LAST_IDX), BASE + w_idx, r_pack, bus.pix_data};
    end

    // Packer: lane counter, word index and partial-word holding bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane <= 2'd0;
            r_idx  <= '0;
            r_pack <= '0;
        end else if (w_accept) begin
            if (w_lane == 2'd3) begin
                r_lane <= 2'd0;
                r_idx  <= (w_idx == LAST_IDX) ? '0 : w_idx + AW'(1);
            end else begin
                r_lane <= w_lane + 2'd1;
                r_idx  <= w_idx;
                case (w_lane)
                    2'd0:    r_pack[23:16] <= bus.pix_data;
                    2'd1:    r_pack[15:8]  <= bus.pix_data;
                    default: r_pack[7:0]   <= bus.pix_data;
                endcase
            end
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    // FIFO pointers and occupancy; the entry under write is popped only on ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW + 1)'(1);
                2'b01:   r_count <= r_count - (PW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Write FSM next state: load the FIFO head when idle, wait for ack when writing.
    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (r_count != '0) begin
                    w_load    = 1'b1;
                    w_state_d = StWrite;
                end
            end
            StWrite: begin
                if (bus.ram_ack) begin
                    w_pop     = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Write FSM state and registered RAM request/frame-done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_frame_done <= w_pop && r_last;
            if (w_load) begin
                r_ram_we                              <= 1'b1;
                {r_last, r_ram_addr, r_ram_wdata}     <= r_mem[r_rptr];
            end else if (w_pop) begin
                r_ram_we <= 1'b0;
            end
        end
    end

endmodule
